// File: rtl/dmem_access_unit_pkg.sv
// Shared types for the data-memory access unit: pipeline request/response bundles,
// memory function and mask encodings, FSM states and the bus request record.
package dmem_access_unit_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } DmemState;

   typedef enum logic {
      M_XRD = 1'b0,
      M_XWR = 1'b1
   } MemoryFcn;

   typedef enum logic [2:0] {
      MT_X  = 3'd0,
      MT_B  = 3'd1,
      MT_H  = 3'd2,
      MT_W  = 3'd3,
      MT_BU = 3'd5,
      MT_HU = 3'd6
   } MemoryMaskType;

   typedef struct packed {
      logic [XLEN-1:0] addr;
      MemoryFcn        fcn;
      MemoryMaskType   typ;
      logic [XLEN-1:0] data;
   } MemReq;

   typedef struct packed {
      logic  req_valid;
      MemReq req;
   } MemoryIn;

   typedef struct packed {
      logic [XLEN-1:0] data;
   } MemResp;

   typedef struct packed {
      MemResp res;
   } MemoryOut;

   typedef struct packed {
      logic [XLEN-1:0] addr;
      logic            we;
      logic [3:0]      strb;
      logic [XLEN-1:0] wdata;
   } DataBusReq;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store strobes and data shift, load extraction with extension,
// and the natural-alignment check for the access size.
module dmem_lane_align
   import dmem_access_unit_pkg::*;
(
   input  MemoryMaskType    typ,
   input  logic [1:0]       offset,
   input  logic [XLEN-1:0]  st_data,
   input  logic [XLEN-1:0]  rd_raw,
   output logic [3:0]       strb,
   output logic [XLEN-1:0]  wdata,
   output logic [XLEN-1:0]  ld_data,
   output logic             misalign
);

   logic [XLEN-1:0] shifted;

   // Lane shift, strobe generation and load extension by access type.
   always_comb begin
      shifted  = rd_raw >> {offset, 3'b000};
      wdata    = st_data << {offset, 3'b000};
      strb     = 4'b0000;
      ld_data  = '0;
      misalign = 1'b0;
      unique case (typ)
         MT_B: begin
            strb    = 4'b0001 << offset;
            ld_data = {{24{shifted[7]}}, shifted[7:0]};
         end
         MT_BU: begin
            strb    = 4'b0001 << offset;
            ld_data = {24'h0, shifted[7:0]};
         end
         MT_H: begin
            strb     = 4'b0011 << offset;
            ld_data  = {{16{shifted[15]}}, shifted[15:0]};
            misalign = offset[0];
         end
         MT_HU: begin
            strb     = 4'b0011 << offset;
            ld_data  = {16'h0, shifted[15:0]};
            misalign = offset[0];
         end
         MT_W: begin
            strb     = 4'b1111;
            ld_data  = shifted;
            misalign = (offset != 2'b00);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/dmem_access_unit.sv
// Memory-stage to valid/ready bus bridge. Holds the access FSM, the request latched at
// issue, the response timeout counter and the captured read word.
module dmem_access_unit
   import dmem_access_unit_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  MemoryIn          dmem_in,
   output MemoryOut         dmem_out,
   output logic             cmiss_stall,
   output logic             misalign,
   output logic             bus_err,
   output logic             bus_req_valid,
   input  logic             bus_req_ready,
   output logic [XLEN-1:0]  bus_req_addr,
   output logic             bus_req_we,
   output logic [3:0]       bus_req_strb,
   output logic [XLEN-1:0]  bus_req_wdata,
   input  logic             bus_rsp_valid,
   input  logic [XLEN-1:0]  bus_rsp_rdata
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

   DmemState        state_q, state_d;
   MemReq           req_q, req_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0] rdata_q, rdata_d;
   logic            mis_q, mis_d;
   logic            err_q, err_d;

   MemReq           cur_req;
   logic [3:0]      lane_strb;
   logic [XLEN-1:0] lane_wdata;
   logic [XLEN-1:0] lane_ld;
   logic            lane_mis;
   DataBusReq       bus_req;

   // In IDLE the live request drives the lanes; afterwards the latched copy does.
   assign cur_req = (state_q == IDLE) ? dmem_in.req : req_q;

   dmem_lane_align u_lane_align (
      .typ      (cur_req.typ),
      .offset   (cur_req.addr[1:0]),
      .st_data  (cur_req.data),
      .rd_raw   (rdata_q),
      .strb     (lane_strb),
      .wdata    (lane_wdata),
      .ld_data  (lane_ld),
      .misalign (lane_mis)
   );

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         req_q   <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
         mis_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         mis_q   <= mis_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic and bus request valid.
   always_comb begin
      state_d       = state_q;
      req_d         = req_q;
      cnt_d         = cnt_q;
      rdata_d       = rdata_q;
      mis_d         = mis_q;
      err_d         = err_q;
      bus_req_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            mis_d = 1'b0;
            err_d = 1'b0;
            if (dmem_in.req_valid) begin
               req_d   = dmem_in.req;
               rdata_d = '0;
               if (lane_mis) begin
                  mis_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  bus_req_valid = 1'b1;
                  state_d       = bus_req_ready ? WAIT : REQ;
               end
            end
         end
         REQ: begin
            bus_req_valid = 1'b1;
            if (bus_req_ready) state_d = WAIT;
         end
         WAIT: begin
            // A response in the timeout cycle takes priority over the error.
            if (bus_rsp_valid) begin
               rdata_d = (req_q.fcn == M_XWR) ? '0 : bus_rsp_rdata;
               state_d = DONE;
            end else if (cnt_q == CntLast) begin
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Bus request fields, zeroed whenever no request is presented.
   always_comb begin
      bus_req = '0;
      if (bus_req_valid) begin
         bus_req.addr  = {cur_req.addr[XLEN-1:2], 2'b00};
         bus_req.we    = (cur_req.fcn == M_XWR);
         bus_req.strb  = lane_strb;
         bus_req.wdata = lane_wdata;
      end
   end

   assign bus_req_addr  = bus_req.addr;
   assign bus_req_we    = bus_req.we;
   assign bus_req_strb  = bus_req.strb;
   assign bus_req_wdata = bus_req.wdata;

   // Pipeline-facing status and load result, presented only in DONE.
   always_comb begin
      dmem_out          = '0;
      cmiss_stall       = dmem_in.req_valid && (state_q != DONE);
      misalign          = (state_q == DONE) && mis_q;
      bus_err           = (state_q == DONE) && err_q;
      if (state_q == DONE) dmem_out.res.data = lane_ld;
   end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: directed vector table, randomized accesses
// against a spec-level model, and hand sequences for kill and mid-access reset.
module tb_dmem_access_unit;
   import dmem_access_unit_pkg::*;

   localparam int NEVER = 100000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   MemoryIn     dmem_in;
   MemoryOut    dmem_out;
   logic        cmiss_stall, misalign, bus_err;
   logic        bus_req_valid, bus_req_ready, bus_req_we;
   logic [31:0] bus_req_addr, bus_req_wdata, bus_rsp_rdata;
   logic [3:0]  bus_req_strb;
   logic        bus_rsp_valid;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [2:0]  typ;
      logic [31:0] data;
      logic [31:0] raw;
      int          rdly;
      int          sdly;
      logic [3:0]  e_strb;
      logic [31:0] e_wdata;
      logic [31:0] e_res;
      logic        e_mis;
      logic        e_err;
      int          e_stall;
   } vec_t;

   dmem_access_unit dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .dmem_in       (dmem_in),
      .dmem_out      (dmem_out),
      .cmiss_stall   (cmiss_stall),
      .misalign      (misalign),
      .bus_err       (bus_err),
      .bus_req_valid (bus_req_valid),
      .bus_req_ready (bus_req_ready),
      .bus_req_addr  (bus_req_addr),
      .bus_req_we    (bus_req_we),
      .bus_req_strb  (bus_req_strb),
      .bus_req_wdata (bus_req_wdata),
      .bus_rsp_valid (bus_rsp_valid),
      .bus_rsp_rdata (bus_rsp_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Spec-level model: size in bytes decides strobe width and alignment.
   function automatic vec_t model(input logic [31:0] addr, input logic we, input logic [2:0] typ,
                                  input logic [31:0] data, input logic [31:0] raw,
                                  input int rdly, input int sdly);
      vec_t v;
      int o, n;
      logic [31:0] word, ld;
      o = int'(addr % 4);
      n = (typ == 3'd1 || typ == 3'd5) ? 1 : (typ == 3'd2 || typ == 3'd6) ? 2 : 4;
      word = raw / (32'd1 << (8 * o));
      if (n == 1) begin
         ld = word % 256;
         if (typ == 3'd1 && ld >= 128) ld = ld - 256;
      end else if (n == 2) begin
         ld = word % 65536;
         if (typ == 3'd2 && ld >= 32768) ld = ld - 65536;
      end else begin
         ld = word;
      end
      v.addr = addr; v.we = we; v.typ = typ; v.data = data; v.raw = raw;
      v.rdly = rdly; v.sdly = sdly;
      v.e_strb  = 4'(((1 << n) - 1) << o);
      v.e_wdata = data * (32'd1 << (8 * o));
      v.e_mis   = (o % n) != 0;
      v.e_err   = 1'b0;
      v.e_res   = (v.e_mis || we) ? 32'h0 : ld;
      v.e_stall = v.e_mis ? 1 : 2 + rdly + sdly;
      return v;
   endfunction

   // Runs one access with a scripted bus; caller is #1 after a posedge.
   task automatic run_vec(input vec_t v, input string tag);
      int cyc = 0, stalls = 0, reqcnt = 0, wcnt = 0;
      bit ph_wait = 0, done = 0, saw_req = 0, unstable = 0, hs, vld;
      logic [31:0] res_s = 0, ad_s = 0, wd_s = 0;
      logic [3:0]  st_s = 0;
      logic        we_s = 0, mis_s = 0, err_s = 0;
      dmem_in.req_valid = 1'b1;
      dmem_in.req.addr  = v.addr;
      dmem_in.req.fcn   = MemoryFcn'(v.we);
      dmem_in.req.typ   = MemoryMaskType'(v.typ);
      dmem_in.req.data  = v.data;
      bus_req_ready = (v.rdly == 0);
      bus_rsp_valid = 1'($urandom_range(0, 1));
      bus_rsp_rdata = $urandom;
      while (!done && cyc < 600) begin
         @(negedge clk);
         vld = bus_req_valid;
         hs  = 1'b0;
         if (vld) begin
            if (saw_req && {bus_req_addr, bus_req_we, bus_req_strb, bus_req_wdata} !==
                {ad_s, we_s, st_s, wd_s}) unstable = 1;
            saw_req = 1;
            ad_s = bus_req_addr; we_s = bus_req_we; st_s = bus_req_strb; wd_s = bus_req_wdata;
            hs = bus_req_ready;
         end
         if (!cmiss_stall) begin
            done = 1; res_s = dmem_out.res.data; mis_s = misalign; err_s = bus_err;
         end else begin
            stalls++;
         end
         @(posedge clk);
         #1;
         cyc++;
         if (done) begin
            dmem_in.req_valid = 1'b0;
            bus_req_ready = 1'b0;
            bus_rsp_valid = 1'b0;
         end else begin
            if (ph_wait) wcnt++;
            if (hs) begin
               ph_wait = 1; wcnt = 0;
            end else if (vld) begin
               reqcnt++;
            end
            bus_req_ready = !ph_wait && (reqcnt >= v.rdly);
            bus_rsp_valid = ph_wait ? (wcnt == v.sdly) : 1'($urandom_range(0, 1));
            bus_rsp_rdata = (ph_wait && wcnt == v.sdly) ? v.raw : $urandom;
         end
      end
      chk({tag, "_completes"}, 32'(done), 32'd1);
      chk({tag, "_stall"}, stalls, v.e_stall);
      chk({tag, "_res"}, res_s, v.e_res);
      chk({tag, "_mis"}, 32'(mis_s), 32'(v.e_mis));
      chk({tag, "_err"}, 32'(err_s), 32'(v.e_err));
      if (v.e_mis) begin
         chk({tag, "_no_bus"}, 32'(saw_req), 32'd0);
      end else begin
         chk({tag, "_bus_seen"}, 32'(saw_req), 32'd1);
         chk({tag, "_addr"}, ad_s, {v.addr[31:2], 2'b00});
         chk({tag, "_we"}, 32'(we_s), 32'(v.we));
         chk({tag, "_strb"}, 32'(st_s), 32'(v.e_strb));
         chk({tag, "_wdata"}, wd_s, v.e_wdata);
         chk({tag, "_stable"}, 32'(unstable), 32'd0);
      end
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_outs"},
          {dmem_out.res.data[27:0], cmiss_stall, misalign, bus_err, bus_req_valid},
          32'h0);
      chk({tag, "_bus"}, {27'h0, bus_req_we, bus_req_strb}, 32'h0);
      chk({tag, "_data_hi"}, {28'h0, dmem_out.res.data[31:28]}, 32'h0);
   endtask

   vec_t tbl[11];

   initial begin
      // addr, we, typ, data, raw, rdly, sdly | strb, wdata, res, mis, err, stall
      tbl[0]  = '{32'h100, 0, 3'd3, 32'h0,      32'hDEADBEEF, 0, 0,
                  4'hF, 32'h0,        32'hDEADBEEF, 0, 0, 2};
      tbl[1]  = '{32'h103, 0, 3'd1, 32'h0,      32'h80123456, 0, 0,
                  4'h8, 32'h0,        32'hFFFFFF80, 0, 0, 2};
      tbl[2]  = '{32'h103, 0, 3'd5, 32'h0,      32'h80123456, 0, 0,
                  4'h8, 32'h0,        32'h00000080, 0, 0, 2};
      tbl[3]  = '{32'h102, 1, 3'd2, 32'h0000ABCD, 32'h55555555, 0, 2,
                  4'hC, 32'hABCD0000, 32'h0,        0, 0, 4};
      tbl[4]  = '{32'h102, 0, 3'd3, 32'h0,      32'h11111111, 0, 0,
                  4'h0, 32'h0,        32'h0,        1, 0, 1};
      tbl[5]  = '{32'h200, 0, 3'd3, 32'h0,      32'h22222222, 3, NEVER,
                  4'hF, 32'h0,        32'h0,        0, 1, 259};
      tbl[6]  = '{32'h102, 0, 3'd2, 32'h0,      32'h80011234, 0, 1,
                  4'hC, 32'h0,        32'hFFFF8001, 0, 0, 3};
      tbl[7]  = '{32'h101, 0, 3'd6, 32'h0,      32'h33333333, 0, 0,
                  4'h0, 32'h0,        32'h0,        1, 0, 1};
      tbl[8]  = '{32'h101, 1, 3'd1, 32'h000000A5, 32'h44444444, 1, 0,
                  4'h2, 32'h0000A500, 32'h0,        0, 0, 3};
      tbl[9]  = '{32'h040, 0, 3'd3, 32'h0,      32'hCAFEF00D, 0, 254,
                  4'hF, 32'h0,        32'hCAFEF00D, 0, 0, 256};
      tbl[10] = '{32'h102, 0, 3'd6, 32'h0,      32'h80011234, 0, 0,
                  4'hC, 32'h0,        32'h00008001, 0, 0, 2};

      dmem_in = '0;
      bus_req_ready = 0; bus_rsp_valid = 0; bus_rsp_rdata = 0;
      repeat (2) @(negedge clk);
      chk_outputs_zero("reset");
      @(posedge clk); #1 rst_n = 1'b1;

      for (int i = 0; i < 11; i++) run_vec(tbl[i], $sformatf("v%0d", i));

      // Kill during WAIT: handshake completes, stall masked, data still presented in DONE.
      dmem_in.req_valid = 1; dmem_in.req.addr = 32'h104;
      dmem_in.req.fcn = M_XRD; dmem_in.req.typ = MT_W;
      bus_req_ready = 1; bus_rsp_valid = 0;
      @(posedge clk); #1;
      dmem_in.req_valid = 0; bus_req_ready = 0; bus_rsp_valid = 1; bus_rsp_rdata = 32'h12345678;
      @(negedge clk);
      chk("kill_wait_stall", 32'(cmiss_stall), 32'd0);
      @(posedge clk); #1 bus_rsp_valid = 0;
      @(negedge clk);
      chk("kill_done_data", dmem_out.res.data, 32'h12345678);
      @(posedge clk); #1;

      // Kill during REQ: request stays presented until accepted.
      dmem_in.req_valid = 1; dmem_in.req.addr = 32'h108; bus_req_ready = 0;
      @(posedge clk); #1 dmem_in.req_valid = 0;
      @(negedge clk);
      chk("kill_req_valid", 32'(bus_req_valid), 32'd1);
      chk("kill_req_addr", bus_req_addr, 32'h108);
      @(posedge clk); #1 bus_req_ready = 1;
      @(posedge clk); #1 bus_req_ready = 0; bus_rsp_valid = 1; bus_rsp_rdata = 32'h0BADF00D;
      @(posedge clk); #1 bus_rsp_valid = 0;
      @(negedge clk);
      chk("kill_req_done_data", dmem_out.res.data, 32'h0BADF00D);
      @(posedge clk); #1;

      // Reset asserted while in WAIT.
      dmem_in.req_valid = 1; dmem_in.req.addr = 32'h300; bus_req_ready = 1;
      @(posedge clk); #1;
      dmem_in.req_valid = 0; bus_req_ready = 0; rst_n = 0;
      @(negedge clk);
      chk_outputs_zero("mid_reset");
      @(posedge clk); #1 rst_n = 1;
      run_vec(tbl[0], "post_reset");

      for (int i = 0; i < 40; i++) begin
         logic [2:0] typs [5];
         vec_t v;
         typs = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6};
         v = model($urandom, 1'($urandom_range(0, 1)), typs[$urandom_range(0, 4)], $urandom,
                   $urandom, $urandom_range(0, 3), $urandom_range(0, 4));
         run_vec(v, $sformatf("r%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
